// File: rtl/rs232_rx.sv
// RS232 receiver: start, 8 data bits MSB first, even parity, one stop bit.
// Each bit is sampled once at its centre; results are delivered one cycle after the stop sample.
module rs232_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_vld,
    output logic       rx_perr,
    output logic       rx_ferr,
    output logic       rx_busy
);

    localparam logic [15:0] CNT_BIT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  sync;
    logic        rxs;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        pbit, pbit_nxt;
    logic        deliver;

    assign rxs     = sync[1];
    assign rx_busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        idx_nxt   = idx;
        shift_nxt = shift;
        pbit_nxt  = pbit;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rxs) state_nxt = START;
            end
            START: begin
                // Line back high at mid-start means the falling edge was a glitch
                if (cnt == CNT_HALF) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT) begin
                    cnt_nxt   = '0;
                    shift_nxt = {shift[6:0], rxs};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (cnt == CNT_BIT) begin
                    cnt_nxt   = '0;
                    pbit_nxt  = rxs;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_BIT) begin
                    cnt_nxt   = '0;
                    deliver   = 1'b1;
                    state_nxt = rxs ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                // A stuck-low line must go high again before another frame can start
                cnt_nxt = '0;
                if (rxs) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync    <= 2'b11;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shift   <= '0;
            pbit    <= 1'b0;
            rx_data <= 8'h00;
            rx_vld  <= 1'b0;
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            sync   <= {sync[0], uart_rx};
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shift  <= shift_nxt;
            pbit   <= pbit_nxt;
            rx_vld <= deliver;
            if (deliver) begin
                rx_data <= shift;
                rx_perr <= (^shift) ^ pbit;
                rx_ferr <= ~rxs;
            end
        end
    end

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx at 8 clocks per bit; frames built bit by bit,
// delivered bytes captured by a monitor and compared against hand-computed values.
module tb_rs232_rx;

    localparam int C = 8;
    localparam int H = C / 2;
    localparam int LAT = 3 + H + 10 * C;   // falling edge to rx_vld, incl. 2-flop sync

    logic       clk_sys = 1'b0;
    logic       rst;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_vld, rx_perr, rx_ferr, rx_busy;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_lat = 0;
    logic [9:0] vq[$];
    int         tq[$];

    rs232_rx #(.CLKS_PER_BIT(C)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_perr (rx_perr),
        .rx_ferr (rx_ferr),
        .rx_busy (rx_busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (rx_vld) begin
            vq.push_back({rx_data, rx_perr, rx_ferr});
            tq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        uart_rx = v;
        repeat (C) @(negedge clk_sys);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        start_cyc = cyc;
        bit_out(1'b0);
        for (int k = 7; k >= 0; k--) bit_out(d[k]);
        bit_out(p);
        bit_out(s);
    endtask

    task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        logic [9:0] e;
        chk($sformatf("%s_cnt", tag), vq.size(), 1);
        if (vq.size() != 0) begin
            e = vq.pop_front();
            last_lat = tq.pop_front() - start_cyc;
            chk($sformatf("%s_data", tag), e[9:2], d);
            chk($sformatf("%s_perr", tag), e[1], pe);
            chk($sformatf("%s_ferr", tag), e[0], fe);
        end
        vq.delete();
        tq.delete();
    endtask

    initial begin
        logic [7:0] good [4];
        logic [9:0] e0, e1;
        int t0, t1;
        good[0] = 8'h11; good[1] = 8'h00; good[2] = 8'h85; good[3] = 8'haa;

        uart_rx = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_vld", rx_vld, 0);
        chk("rst_perr", rx_perr, 0);
        chk("rst_ferr", rx_ferr, 0);
        chk("rst_busy", rx_busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk_sys);

        // good frames with long idle gaps; first one also pins the latency
        for (int i = 0; i < 4; i++) begin
            send_frame(good[i], ^good[i], 1'b1);
            repeat (4) @(negedge clk_sys);
            expect_frame($sformatf("good%0d", i), good[i], 1'b0, 1'b0);
            if (i == 0) chk("latency", last_lat, LAT);
            repeat (200) @(negedge clk_sys);
            chk($sformatf("hold%0d", i), rx_data, good[i]);
        end

        // wrong parity bit
        send_frame(8'h85, 1'b0, 1'b1);
        repeat (4) @(negedge clk_sys);
        expect_frame("perr", 8'h85, 1'b1, 1'b0);
        repeat (50) @(negedge clk_sys);

        // stop bit low, line then held low
        send_frame(8'haa, 1'b0, 1'b0);
        repeat (30 * C) @(negedge clk_sys);
        expect_frame("ferr", 8'haa, 1'b0, 1'b1);
        chk("ferr_wait_busy", rx_busy, 1);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk_sys);
        chk("ferr_idle_busy", rx_busy, 0);
        chk("ferr_no_extra", vq.size(), 0);
        send_frame(8'h11, 1'b0, 1'b1);
        repeat (4) @(negedge clk_sys);
        expect_frame("after_ferr", 8'h11, 1'b0, 1'b0);
        repeat (50) @(negedge clk_sys);

        // 2-cycle glitch
        uart_rx = 1'b0;
        repeat (2) @(negedge clk_sys);
        uart_rx = 1'b1;
        repeat (2) @(negedge clk_sys);
        chk("glitch_busy", rx_busy, 1);
        repeat (H + 3 - 4) @(negedge clk_sys);
        chk("glitch_idle", rx_busy, 0);
        repeat (20) @(negedge clk_sys);
        chk("glitch_no_vld", vq.size(), 0);
        send_frame(8'h11, 1'b0, 1'b1);
        repeat (4) @(negedge clk_sys);
        expect_frame("after_glitch", 8'h11, 1'b0, 1'b0);
        repeat (50) @(negedge clk_sys);

        // reset in the middle of D3 of an 8'h85 frame
        start_cyc = cyc;
        bit_out(1'b0);
        bit_out(1'b1); bit_out(1'b0); bit_out(1'b0); bit_out(1'b0);
        uart_rx = 1'b0;
        repeat (H) @(negedge clk_sys);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("midrst_busy", rx_busy, 0);
        chk("midrst_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (12 * C) @(negedge clk_sys);
        chk("midrst_no_vld", vq.size(), 0);
        send_frame(8'h85, 1'b1, 1'b1);
        repeat (4) @(negedge clk_sys);
        expect_frame("after_rst", 8'h85, 1'b0, 1'b0);
        repeat (50) @(negedge clk_sys);

        // back-to-back frames, zero idle between them
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'haa, 1'b0, 1'b1);
        repeat (4) @(negedge clk_sys);
        chk("b2b_cnt", vq.size(), 2);
        if (vq.size() >= 2) begin
            e0 = vq.pop_front(); e1 = vq.pop_front();
            t0 = tq.pop_front(); t1 = tq.pop_front();
            chk("b2b_data0", e0, {8'h11, 2'b00});
            chk("b2b_data1", e1, {8'haa, 2'b00});
            chk("b2b_gap", t1 - t0, 11 * C);
        end
        vq.delete();
        tq.delete();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
